// File: rtl/ff256_ct_seq_param_pkg.sv
// ff256_ct_seq_param_pkg: shared states, register bit positions and coefficient helpers
package ff256_ct_seq_param_pkg;

    typedef enum logic [2:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam int CTRL_START = 0;
    localparam int CTRL_CLEAR = 1;

    localparam int STAT_DONE  = 0;
    localparam int STAT_BUSY  = 1;
    localparam int STAT_STATE = 2;
    localparam int STAT_K     = 5;

    localparam logic [8:0] DEFAULT_POLY = 9'h11D;

    // Flat image of logic [0:n-1][0:n-1][7:0]; element [k][m] sits at bit ((n-1-k)*n+(n-1-m))*8
    function automatic logic [2047:0] identity_coef(input int n);
        identity_coef = '0;
        for (int i = 0; i < n; i++) identity_coef[(n - 1 - i) * (n + 1) * 8] = 1'b1;
    endfunction

endpackage

// File: rtl/ff256_gf_mult.sv
// ff256_gf_mult: combinational GF(2^8) multiplier reduced by POLY
module ff256_gf_mult
    import ff256_ct_seq_param_pkg::*;
#(
    parameter logic [8:0] POLY = DEFAULT_POLY
)(
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] p
);
    logic [7:0] sh;

    always_comb begin
        p  = '0;
        sh = a;
        for (int i = 0; i < 8; i++) begin
            p  = b[i] ? p ^ sh : p;
            sh = {sh[6:0], 1'b0} ^ (sh[7] ? POLY[7:0] : 8'h00);
        end
    end

endmodule

// File: rtl/ff256_ct_seq_param.sv
// ff256_ct_seq_param: sequential GF(2^8) matrix transform engine with a Wishbone slave port
module ff256_ct_seq_param
    import ff256_ct_seq_param_pkg::*;
#(
    parameter int                          N          = 8,
    parameter logic [8:0]                  POLY       = DEFAULT_POLY,
    parameter logic [0:N-1][0:N-1][7:0]    COEF       = (N*N*8)'(identity_coef(N)),
    parameter int                          DATA_WIDTH = 32,
    parameter int                          ADR_WIDTH  = 4
)(
    input  logic                      clk,
    input  logic                      reset,
    input  logic [ADR_WIDTH-1:0]      adr_i,
    input  logic [DATA_WIDTH-1:0]     data_i,
    output logic [DATA_WIDTH-1:0]     data_o,
    input  logic                      we_i,
    input  logic [DATA_WIDTH/8-1:0]   sel_i,
    input  logic                      stb_i,
    input  logic                      cyc_i,
    output logic                      ack_o,
    output logic                      busy_o,
    output logic                      done_o
);
    localparam int W  = N / 4;
    localparam int KW = $clog2(N);
    localparam logic [ADR_WIDTH-1:0] A_CTRL = ADR_WIDTH'(W);
    localparam logic [ADR_WIDTH-1:0] A_STAT = ADR_WIDTH'(W + 1);

    state_t                state;
    logic [4:0]            k;
    logic [W-1:0][31:0]    in_w;
    logic [N-1:0][7:0]     x_s, prod, prod_c, work, res;
    logic                  pv;
    logic [7:0]            red;
    logic [31:0]           status;
    logic                  acc, wr, start, clr;

    assign acc   = stb_i & cyc_i & ~ack_o;
    assign wr    = acc & we_i;
    assign start = wr && adr_i == A_CTRL && data_i[CTRL_START];
    assign clr   = wr && adr_i == A_CTRL && data_i[CTRL_CLEAR];

    for (genvar i = 0; i < N; i++) begin : g_mul
        ff256_gf_mult #(.POLY(POLY)) u_mul (
            .a(COEF[k[KW-1:0]][i]),
            .b(x_s[i]),
            .p(prod_c[i])
        );
    end

    always_comb begin
        red = '0;
        for (int i = 0; i < N; i++) red = red ^ prod[i];
    end

    always_comb begin
        status                  = '0;
        status[STAT_DONE]       = done_o;
        status[STAT_BUSY]       = busy_o;
        status[STAT_STATE +: 3] = state;
        status[STAT_K +: 5]     = k;
    end

    always_comb begin
        data_o = 32'hAABBCCDD;
        for (int i = 0; i < W; i++) data_o = adr_i == ADR_WIDTH'(i) ? in_w[i] : data_o;
        data_o = adr_i == A_CTRL ? '0 : data_o;
        data_o = adr_i == A_STAT ? status : data_o;
        for (int i = 0; i < W; i++) data_o = adr_i == ADR_WIDTH'(W + 2 + i) ? res[4*i +: 4] : data_o;
    end

    // Row k is registered as products at E(k+1) and shifted into work at E(k+2)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            k      <= '0;
            busy_o <= 1'b0;
            done_o <= 1'b0;
            ack_o  <= 1'b0;
            in_w   <= '0;
            x_s    <= '0;
            prod   <= '0;
            pv     <= 1'b0;
            work   <= '0;
            res    <= '0;
        end else begin
            ack_o <= acc;
            for (int i = 0; i < W; i++)
                for (int b = 0; b < 4; b++)
                    if (wr && !busy_o && adr_i == ADR_WIDTH'(i) && sel_i[b])
                        in_w[i][8*b +: 8] <= data_i[8*b +: 8];
            pv <= state == RUN;
            if (state == RUN) prod <= prod_c;
            if (pv) work <= {red, work[N-1:1]};
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state  <= RUN;
                        k      <= '0;
                        x_s    <= in_w;
                        busy_o <= 1'b1;
                        done_o <= 1'b0;
                    end else if (clr && state == DONE) begin
                        state  <= IDLE;
                        done_o <= 1'b0;
                    end
                end
                RUN: begin
                    k <= k + 5'd1;
                    if (k == 5'(N - 1)) state <= DRAIN;
                end
                DRAIN: begin
                    k <= k + 5'd1;
                    if (k == 5'(N + 1)) begin
                        state  <= DONE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                        res    <= work;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ff256_ct_seq_param.sv
// tb_ff256_ct_seq_param: directed checks on three engine configurations sharing one bus
module tb_ff256_ct_seq_param;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  adr = '0;
    logic [31:0] wdat = '0;
    logic        we = 1'b0;
    logic [3:0]  sel = '0;
    logic        cyc = 1'b0;
    logic [2:0]  stb = '0;
    logic [2:0]  ack, busy, done;
    logic [31:0] dout [3];
    int          checks = 0;
    int          errors = 0;
    int          cyc_cnt = 0;

    localparam logic [0:7][0:7][7:0] ONES = {64{8'h01}};
    localparam logic [0:3][0:3][7:0] ROW0 = {{4{8'h02}}, {12{8'h00}}};

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt++;

    ff256_ct_seq_param #(.N(8)) u_id (
        .clk(clk), .reset(reset), .adr_i(adr), .data_i(wdat), .data_o(dout[0]), .we_i(we),
        .sel_i(sel), .stb_i(stb[0]), .cyc_i(cyc), .ack_o(ack[0]), .busy_o(busy[0]), .done_o(done[0]));
    ff256_ct_seq_param #(.N(8), .COEF(ONES)) u_ones (
        .clk(clk), .reset(reset), .adr_i(adr), .data_i(wdat), .data_o(dout[1]), .we_i(we),
        .sel_i(sel), .stb_i(stb[1]), .cyc_i(cyc), .ack_o(ack[1]), .busy_o(busy[1]), .done_o(done[1]));
    ff256_ct_seq_param #(.N(4), .COEF(ROW0)) u_n4 (
        .clk(clk), .reset(reset), .adr_i(adr), .data_i(wdat), .data_o(dout[2]), .we_i(we),
        .sel_i(sel), .stb_i(stb[2]), .cyc_i(cyc), .ack_o(ack[2]), .busy_o(busy[2]), .done_o(done[2]));

    task automatic bus(input int d, input logic [3:0] a, input logic w, input logic [31:0] v,
                       input logic [3:0] s, output logic [31:0] r);
        int n;
        @(negedge clk);
        adr = a; wdat = v; we = w; sel = s; cyc = 1'b1; stb[d] = 1'b1;
        #1 r = dout[d];
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!ack[d] && n < 8);
        stb[d] = 1'b0; cyc = 1'b0; we = 1'b0;
        checks++;
        if (ack[d] !== 1'b1) begin
            errors++;
            $display("FAIL bus_ack dut%0d adr %0d: ack %b want 1", d, a, ack[d]);
        end
    endtask

    task automatic wr(input int d, input logic [3:0] a, input logic [31:0] v);
        logic [31:0] r;
        bus(d, a, 1'b1, v, 4'hF, r);
    endtask

    task automatic rd(input int d, input logic [3:0] a, output logic [31:0] r);
        bus(d, a, 1'b0, 32'h0, 4'hF, r);
    endtask

    task automatic wait_done(input int d, output int n);
        n = 0;
        while (!done[d] && n < 40) begin
            @(posedge clk); #1; n++;
        end
    endtask

    task automatic test_reset;
        logic [31:0] r;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 3'b000 || done !== 3'b000 || ack !== 3'b000) begin
            errors++;
            $display("FAIL reset_outputs: busy %b done %b ack %b want 000", busy, done, ack);
        end
        @(negedge clk) reset = 1'b1;
        rd(0, 4'd3, r);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL reset_status: got %h want 00000000", r); end
        rd(0, 4'd4, r);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 00000000", r); end
        rd(2, 4'd2, r);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL reset_status_n4: got %h want 00000000", r); end
    endtask

    task automatic test_identity;
        logic [31:0] r;
        int n;
        wr(0, 4'd0, 32'h04030201);
        wr(0, 4'd1, 32'h08070605);
        wr(0, 4'd2, 32'h1);
        checks++;
        if (busy[0] !== 1'b1 || done[0] !== 1'b0) begin
            errors++;
            $display("FAIL id_busy_after_start: busy %b done %b want 1 0", busy[0], done[0]);
        end
        wait_done(0, n);
        checks++;
        if (n !== 10) begin errors++; $display("FAIL id_done_latency: got %0d want 10", n); end
        rd(0, 4'd4, r);
        checks++;
        if (r !== 32'h04030201) begin errors++; $display("FAIL id_res0: got %h want 04030201", r); end
        rd(0, 4'd5, r);
        checks++;
        if (r !== 32'h08070605) begin errors++; $display("FAIL id_res1: got %h want 08070605", r); end
        rd(0, 4'd3, r);
        checks++;
        if (r[4:0] !== 5'b01101) begin errors++; $display("FAIL id_status: got %b want 01101", r[4:0]); end
    endtask

    task automatic test_all_ones;
        logic [31:0] r;
        int n;
        wr(1, 4'd0, 32'h04030201);
        wr(1, 4'd1, 32'h08070605);
        wr(1, 4'd2, 32'h1);
        wait_done(1, n);
        checks++;
        if (n !== 10) begin errors++; $display("FAIL ones_done_latency: got %0d want 10", n); end
        rd(1, 4'd4, r);
        checks++;
        if (r !== 32'h08080808) begin errors++; $display("FAIL ones_res0: got %h want 08080808", r); end
        rd(1, 4'd5, r);
        checks++;
        if (r !== 32'h08080808) begin errors++; $display("FAIL ones_res1: got %h want 08080808", r); end
    endtask

    task automatic test_reduce;
        logic [31:0] r;
        int n;
        wr(2, 4'd0, 32'h00000080);
        wr(2, 4'd1, 32'h1);
        wait_done(2, n);
        checks++;
        if (n !== 6) begin errors++; $display("FAIL n4_done_latency: got %0d want 6", n); end
        rd(2, 4'd3, r);
        checks++;
        if (r !== 32'h0000001D) begin errors++; $display("FAIL n4_poly_reduce: got %h want 0000001d", r); end
        wr(2, 4'd4, 32'h12345678);
        rd(2, 4'd4, r);
        checks++;
        if (r !== 32'hAABBCCDD) begin errors++; $display("FAIL n4_unmapped: got %h want aabbccdd", r); end
        bus(2, 4'd0, 1'b1, 32'hFFFFFFFF, 4'b0100, r);
        rd(2, 4'd0, r);
        checks++;
        if (r !== 32'h00FF0080) begin errors++; $display("FAIL n4_byte_sel: got %h want 00ff0080", r); end
    endtask

    task automatic test_busy_protect;
        logic [31:0] r;
        int e0, n;
        wr(0, 4'd2, 32'h1);
        e0 = cyc_cnt;
        wr(0, 4'd0, 32'hFFFFFFFF);
        wr(0, 4'd2, 32'h1);
        checks++;
        if (busy[0] !== 1'b1) begin errors++; $display("FAIL prot_busy: got %b want 1", busy[0]); end
        wait_done(0, n);
        checks++;
        if (cyc_cnt - e0 !== 10) begin errors++; $display("FAIL prot_done_latency: got %0d want 10", cyc_cnt - e0); end
        rd(0, 4'd0, r);
        checks++;
        if (r !== 32'h04030201) begin errors++; $display("FAIL prot_input_kept: got %h want 04030201", r); end
        rd(0, 4'd4, r);
        checks++;
        if (r !== 32'h04030201) begin errors++; $display("FAIL prot_res0: got %h want 04030201", r); end
        rd(0, 4'd5, r);
        checks++;
        if (r !== 32'h08070605) begin errors++; $display("FAIL prot_res1: got %h want 08070605", r); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] r;
        int e0, n;
        wr(1, 4'd0, 32'h00000001);
        wr(1, 4'd1, 32'h00000000);
        wr(1, 4'd2, 32'h1);
        e0 = cyc_cnt;
        rd(1, 4'd4, r);
        checks++;
        if (r !== 32'h08080808) begin errors++; $display("FAIL b2b_old_result: got %h want 08080808", r); end
        wait_done(1, n);
        checks++;
        if (cyc_cnt - e0 !== 10) begin errors++; $display("FAIL b2b_latency: got %0d want 10", cyc_cnt - e0); end
        rd(1, 4'd5, r);
        checks++;
        if (r !== 32'h01010101) begin errors++; $display("FAIL b2b_res1: got %h want 01010101", r); end
        wr(1, 4'd2, 32'h1);
        checks++;
        if (busy[1] !== 1'b1 || done[1] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_restart: busy %b done %b want 1 0", busy[1], done[1]);
        end
        wait_done(1, n);
        checks++;
        if (n !== 10) begin errors++; $display("FAIL b2b_restart_latency: got %0d want 10", n); end
    endtask

    task automatic test_handshake;
        logic [31:0] r;
        int n;
        @(negedge clk);
        adr = 4'd2; we = 1'b0; cyc = 1'b1; stb[2] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checks++;
            if (ack[2] !== ((i % 2) == 0)) begin
                errors++;
                $display("FAIL hs_ack_cycle%0d: got %b want %b", i, ack[2], (i % 2) == 0);
            end
        end
        stb[2] = 1'b0; cyc = 1'b0;
        wr(2, 4'd1, 32'h2);
        checks++;
        if (done[2] !== 1'b0 || busy[2] !== 1'b0) begin
            errors++;
            $display("FAIL hs_clear_done: busy %b done %b want 0 0", busy[2], done[2]);
        end
        rd(2, 4'd2, r);
        checks++;
        if (r[4:0] !== 5'b00000) begin errors++; $display("FAIL hs_idle_status: got %b want 00000", r[4:0]); end
        wr(2, 4'd1, 32'h3);
        checks++;
        if (busy[2] !== 1'b1) begin errors++; $display("FAIL hs_start_wins: got %b want 1", busy[2]); end
        wait_done(2, n);
        checks++;
        if (n !== 6) begin errors++; $display("FAIL hs_run_latency: got %0d want 6", n); end
    endtask

    task automatic test_reset_midrun;
        logic [31:0] r;
        wr(0, 4'd2, 32'h1);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy[0] !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b want 1", busy[0]); end
        reset = 1'b0;
        #1;
        checks++;
        if (busy !== 3'b000 || done !== 3'b000 || ack !== 3'b000) begin
            errors++;
            $display("FAIL mid_reset_outputs: busy %b done %b ack %b want 000", busy, done, ack);
        end
        @(negedge clk) reset = 1'b1;
        rd(0, 4'd3, r);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL mid_status: got %h want 00000000", r); end
        rd(0, 4'd4, r);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL mid_result: got %h want 00000000", r); end
        rd(0, 4'd0, r);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL mid_input: got %h want 00000000", r); end
    endtask

    initial begin
        test_reset;
        test_identity;
        test_all_ones;
        test_reduce;
        test_busy_protect;
        test_back_to_back;
        test_handshake;
        test_reset_midrun;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ff256_ct_seq_param.md
# ff256_ct_seq_param

Parametrised sequential GF(2^8) cosine-transform engine behind a Wishbone slave port. It computes X[k] = XOR over n of C[k][n]·x[n] for k, n = 0..N-1, with a configurable transform length, coefficient matrix and field polynomial. It has a start/busy/done handshake, a registered bus acknowledge, and a double-buffered result. It sits on the peripheral bus as the successor to the fixed 8-point engine.

## Interface
- N, 8: transform length; legal values are 4, 8 and 16.
- POLY, 9'h11D: field reduction polynomial.
- COEF, identity: logic [7:0] [0:N-1][0:N-1] coefficient matrix C[k][n].
- DATA_WIDTH, 32: bus data width; fixed at 32.
- ADR_WIDTH, 4: word-address width; must satisfy 2^ADR_WIDTH ≥ N/2+2.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low.
- adr_i  in  ADR_WIDTH  word address.
- data_i  in  32  write data.
- data_o  out  32  read data; combinational from adr_i.
- we_i  in  1  write enable.
- sel_i  in  4  byte-lane enables; honoured on input-word writes only.
- stb_i, cyc_i  in  1  strobe and cycle.
- ack_o  out  1  acknowledge; registered.
- busy_o  out  1  high in RUN and DRAIN.
- done_o  out  1  high in DONE.

## Operation
- W = N/4 input words. Sample x[n] is byte n%4 of input word n/4.
- Register map:
  - 0..W-1: input words (R/W).
  - W: CTRL (W). Bit0 = start, bit1 = clear_done; both self-clearing.
  - W+1: STATUS (R) = {22'd0, k[4:0], state[2:0], busy, done}.
  - W+2..2W+1: result words (R). Same byte packing as the inputs.
  - Any other address reads 32'hAABBCCDD; writes to it are ignored.
- A bus access is accepted when stb_i & cyc_i & !ack_o. Each accepted access gives exactly one single-cycle ack pulse.
- Writes to input words are ignored while busy. They are still acknowledged.
- FSM states and transitions:
  - IDLE: on a start write, snapshot the inputs into x_s, set k = 0, go to RUN.
  - RUN: each cycle, register all N products C[k][n]·x_s[n] into the product stage; k++. After k = N-1 is issued, go to DRAIN.
  - DRAIN: 2 cycles to flush the product stage and the XOR-reduce stage. Each reduced row is shifted into the working buffer.
  - DONE: the working buffer is copied into the result buffer atomically on entry. Stays in DONE until a start or clear_done write.
    - A start write in DONE restarts directly into RUN.
    - A clear_done write in DONE goes to IDLE.
- A start write during RUN or DRAIN is ignored.
- If start and clear_done are written together, start wins.
- The result buffer changes only on DONE entry. Reads during a run return the previous result.
- Arithmetic is GF(2^8) multiplication, reduced by POLY, followed by an N-input XOR. There is no carry and no saturation.
- Any reset assertion, including mid-run, returns the block to IDLE asynchronously. All registers clear.

## Timing
- Reset values:
  - ack_o = 0, busy_o = 0, done_o = 0.
  - State = IDLE, k = 0.
  - Input, snapshot, pipeline and result buffers all 0.
- ack_o rises on the clock edge after acceptance and falls on the next edge.
- Let E0 be the edge that registers an accepted start write:
  - busy_o = 1 after E0.
  - RUN lasts N cycles, then DRAIN lasts 2 cycles.
  - done_o = 1 and the new result are visible after edge E(N+2).
- For N = 8, results are readable 10 cycles after E0. Throughput is one transform per N+2 cycles with back-to-back starts.

## Structure
- Package ff256_ct_seq_param_pkg holds:
  - state enum IDLE/RUN/DRAIN/DONE;
  - CTRL and STATUS bit positions;
  - the default POLY;
  - an identity-matrix generator function for COEF.
- Sub-module ff256_gf_mult: combinational 8×8 GF(2^8) multiplier parametrised by POLY. Instantiate N copies.
- The top level holds the bus decode, FSM, k counter, pipeline registers and buffers.

## Test plan
1. Reset mid-run: assert reset during RUN → busy_o = 0, done_o = 0, ack_o = 0, and STATUS reads 0 on the next read.
2. N = 8, identity COEF: inputs 0x04030201 and 0x08070605, then start → done_o exactly 10 cycles after E0; results read 0x04030201 and 0x08070605.
3. N = 8, all-ones COEF: same inputs → every result byte is 0x08, so both words read 0x08080808.
4. N = 4, COEF row 0 = 0x02 and other rows 0, x[0] = 0x80 → result word 0x0000001D (tests reduction by POLY).
5. Busy protection: during RUN, write input word 0 with 0xFFFFFFFF and issue a second start → both are acknowledged, the result is unchanged from scenario 2, and done_o timing is unchanged.
6. Handshake: hold stb_i & cyc_i high for 4 cycles → ack_o pulses on alternating cycles. Then clear_done in DONE → IDLE with done_o = 0. Then start and clear_done together → a run starts.
